// File: rtl/clint_timer.sv
// clint_timer: single-hart CLINT with msip, mtimecmp and a prescaled mtime.
// One-cycle valid/ready register port; mtip is registered from mtime >= mtimecmp.
module clint_timer #(
  parameter logic [31:0] clint_base_addr = 32'h2000000,
  parameter int unsigned clock_divider   = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  localparam int unsigned PW =
    (clock_divider > 1) ? $clog2(clock_divider) : 1;
  localparam logic [PW-1:0] TC = PW'(clock_divider - 1);

  localparam logic [13:0] W_MSIP  = 14'h0000;
  localparam logic [13:0] W_CMPLO = 14'h1000;
  localparam logic [13:0] W_CMPHI = 14'h1001;
  localparam logic [13:0] W_MTLO  = 14'h2FFE;
  localparam logic [13:0] W_MTHI  = 14'h2FFF;

  logic          msip_q, msip_d;
  logic [63:0]   cmp_q, cmp_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          mtip_q, mtip_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [15:0] off;
  logic [13:0] widx;
  logic        wr;
  logic        tick;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign off       = clint_addr[15:0] - clint_base_addr[15:0];
  assign widx      = off[15:2];
  assign unused_ok = ^{clint_addr[31:16], off[1:0]};
  assign wr        = clint_valid & ~clint_instr & (|clint_wstrb);
  assign tick      = (pre_q == TC);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (strb[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Read mux: register value before this cycle's tick or write.
  always_comb begin
    rd_val = 32'h0;
    case (widx)
      W_MSIP:  rd_val = {31'h0, msip_q};
      W_CMPLO: rd_val = cmp_q[31:0];
      W_CMPHI: rd_val = cmp_q[63:32];
      W_MTLO:  rd_val = mtime_q[31:0];
      W_MTHI:  rd_val = mtime_q[63:32];
      default: rd_val = 32'h0;
    endcase
  end

  // Next state: prescaler tick, then writes override the mtime increment.
  always_comb begin
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    mtime_d = mtime_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr) begin
      case (widx)
        W_MSIP:
          if (clint_wstrb[0]) msip_d = clint_wdata[0];
        W_CMPLO:
          cmp_d[31:0] = merge(cmp_q[31:0], clint_wdata, clint_wstrb);
        W_CMPHI:
          cmp_d[63:32] = merge(cmp_q[63:32], clint_wdata, clint_wstrb);
        W_MTLO:
          mtime_d = {mtime_q[63:32],
                     merge(mtime_q[31:0], clint_wdata, clint_wstrb)};
        W_MTHI:
          mtime_d = {merge(mtime_q[63:32], clint_wdata, clint_wstrb),
                     mtime_q[31:0]};
        default: ;
      endcase
    end
    mtip_d  = (mtime_q >= cmp_q);
    ready_d = clint_valid;
    rdata_d = (clint_valid && !clint_instr) ? rd_val : 32'h0;
  end

  // State registers; reset aborts any pending response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip_q  <= 1'b0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q <= 64'h0;
      pre_q   <= '0;
      mtip_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      msip_q  <= msip_d;
      cmp_q   <= cmp_d;
      mtime_q <= mtime_d;
      pre_q   <= pre_d;
      mtip_q  <= mtip_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = ready_q;
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;
  assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: table vectors, corner sequences and random traffic
// checked against a cycle-count based model of the CLINT.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h2000000;
  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clint_valid = 1'b0;
  logic        clint_instr = 1'b0;
  logic [31:0] clint_addr = 32'h0;
  logic [31:0] clint_wdata = 32'h0;
  logic [3:0]  clint_wstrb = 4'h0;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        clint_msip;
  logic        clint_mtip;
  logic [63:0] clint_mtime;

  clint_timer #(.clint_base_addr(BASE), .clock_divider(DIV)) dut (
    .clock(clock), .reset(reset),
    .clint_valid(clint_valid), .clint_instr(clint_instr),
    .clint_addr(clint_addr), .clint_wdata(clint_wdata),
    .clint_wstrb(clint_wstrb), .clint_rdata(clint_rdata),
    .clint_ready(clint_ready), .clint_msip(clint_msip),
    .clint_mtip(clint_mtip), .clint_mtime(clint_mtime)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // model state
  logic        m_msip;
  logic [63:0] m_cmp, m_time;
  logic        m_mtip, m_rdy;
  logic [31:0] m_rd;
  int          m_cyc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_msip = 0; m_cmp = '1; m_time = 0;
    m_mtip = 0; m_rdy = 0; m_rd = 0; m_cyc = 0;
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o,
    input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++)
      if (s[k]) r[8*k +: 8] = w[8*k +: 8];
    return r;
  endfunction

  // One clock: drive request, advance model at the edge, compare after.
  task automatic cycle(input logic v, input logic ins,
    input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] o, rv;
    logic tk, w;
    clint_valid = v; clint_instr = ins; clint_addr = a;
    clint_wdata = wd; clint_wstrb = s;
    @(posedge clock);
    o = (a - BASE) & 32'h0000_FFFC;
    case (o)
      32'h0000: rv = {31'b0, m_msip};
      32'h4000: rv = m_cmp[31:0];
      32'h4004: rv = m_cmp[63:32];
      32'hBFF8: rv = m_time[31:0];
      32'hBFFC: rv = m_time[63:32];
      default:  rv = 0;
    endcase
    m_rdy = v;
    m_rd = (v && !ins) ? rv : 32'h0;
    m_mtip = (m_time >= m_cmp);
    tk = (m_cyc % DIV) == DIV - 1;
    m_cyc++;
    w = v && !ins && (s != 0);
    if (w && o == 32'hBFF8)
      m_time[31:0] = mrg(m_time[31:0], wd, s);
    else if (w && o == 32'hBFFC)
      m_time[63:32] = mrg(m_time[63:32], wd, s);
    else if (tk)
      m_time = m_time + 1;
    if (w && o == 32'h0000 && s[0]) m_msip = wd[0];
    if (w && o == 32'h4000) m_cmp[31:0] = mrg(m_cmp[31:0], wd, s);
    if (w && o == 32'h4004) m_cmp[63:32] = mrg(m_cmp[63:32], wd, s);
    #1;
    chk("ready", clint_ready, m_rdy);
    chk("rdata", clint_rdata, m_rd);
    chk("msip", clint_msip, m_msip);
    chk("mtip", clint_mtip, m_mtip);
    chk("mtime", clint_mtime, m_time);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d);
    cycle(1, 0, BASE + {16'h0, off}, d, 4'hF);
  endtask

  typedef struct {
    logic        instr;
    logic [15:0] off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        is_rd;
    logic [31:0] exp_rd;
    logic        exp_msip;
  } vec_t;

  vec_t vt[15];
  logic [15:0] offs[7];
  logic [63:0] prev;
  int last, found;
  logic seen;

  initial begin
    vt[0]  = '{0, 16'h4004, 0, 4'h0, 1, 32'hFFFF_FFFF, 0};
    vt[1]  = '{0, 16'hBFF8, 0, 4'h0, 1, 32'h0, 0};
    vt[2]  = '{0, 16'h0000, 32'h1, 4'h1, 0, 32'h0, 1};
    vt[3]  = '{0, 16'h0000, 0, 4'h0, 1, 32'h1, 1};
    vt[4]  = '{0, 16'h0000, 32'h0, 4'h2, 0, 32'h0, 1};
    vt[5]  = '{0, 16'h0000, 0, 4'h0, 1, 32'h1, 1};
    vt[6]  = '{1, 16'h0000, 0, 4'h0, 1, 32'h0, 1};
    vt[7]  = '{0, 16'h0000, 32'h0, 4'h1, 0, 32'h0, 0};
    vt[8]  = '{0, 16'h0000, 0, 4'h0, 1, 32'h0, 0};
    vt[9]  = '{0, 16'h4000, 32'hAABB_CCDD, 4'h5, 0, 32'h0, 0};
    vt[10] = '{0, 16'h4000, 0, 4'h0, 1, 32'hFFBB_FFDD, 0};
    vt[11] = '{0, 16'h1000, 0, 4'h0, 1, 32'h0, 0};
    vt[12] = '{0, 16'h8000, 32'h1234, 4'hF, 0, 32'h0, 0};
    vt[13] = '{0, 16'h8000, 0, 4'h0, 1, 32'h0, 0};
    vt[14] = '{0, 16'h4000, 0, 4'h0, 1, 32'hFFBB_FFDD, 0};
    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
             16'hBFFC, 16'h1000, 16'h8000};

    model_reset();
    #12;
    chk("rst_ready", clint_ready, 0);
    chk("rst_rdata", clint_rdata, 0);
    chk("rst_msip", clint_msip, 0);
    chk("rst_mtip", clint_mtip, 0);
    chk("rst_mtime", clint_mtime, 0);
    reset = 1'b1;

    // register map vectors, back to back
    foreach (vt[i]) begin
      cycle(1, vt[i].instr, BASE + {16'h0, vt[i].off},
            vt[i].wdata, vt[i].wstrb);
      chk($sformatf("vec%0d_ready", i), clint_ready, 1);
      if (vt[i].is_rd)
        chk($sformatf("vec%0d_rdata", i), clint_rdata, vt[i].exp_rd);
      chk($sformatf("vec%0d_msip", i), clint_msip, vt[i].exp_msip);
    end
    idle();
    chk("ready_one_cycle", clint_ready, 0);

    // timer interrupt with divider 4
    wr(16'hBFFC, 0);
    wr(16'hBFF8, 0);
    wr(16'h4004, 0);
    wr(16'h4000, 3);
    prev = clint_mtime; last = 0; seen = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      idle();
      if (clint_mtime != prev) begin
        if (seen) chk("mtime_period", k - last, DIV);
        seen = 1; last = k; prev = clint_mtime;
      end
      if (clint_mtime == 3) found = 1;
    end
    chk("mtime_reach3", found, 1);
    chk("mtip_before", clint_mtip, 0);
    idle();
    chk("mtip_rise", clint_mtip, 1);
    wr(16'h4000, 32'hFFFF_FFFF);
    chk("mtip_hold1", clint_mtip, 1);
    idle();
    chk("mtip_fall2", clint_mtip, 0);

    // wrap: write all-ones away from the tick
    while ((m_cyc % DIV) != 0) idle();
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    chk("mtime_ones", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    idle();
    chk("mtime_wrap", clint_mtime, 0);

    // write collides with tick: no increment
    while ((m_cyc % DIV) != DIV - 1) idle();
    wr(16'hBFF8, 5);
    chk("collide_lo", clint_mtime[31:0], 5);

    // reset mid-transaction aborts the response
    clint_valid = 1; clint_instr = 0;
    clint_addr = BASE; clint_wstrb = 0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_ready", clint_ready, 0);
    chk("abort_mtime", clint_mtime, 0);
    @(posedge clock);
    clint_valid = 0;
    @(negedge clock);
    reset = 1'b1;
    idle();
    chk("abort_no_resp", clint_ready, 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = ($urandom % 2) ? $urandom : $urandom_range(0, 24);
      cycle(($urandom % 3) != 0, ($urandom % 8) == 0,
            BASE + {16'h0, offs[$urandom % 7]}, d, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
